// File: rtl/regfile_clr_bypass.sv
// Parameterised register file: 2 combinational read ports, 1 synchronous write port, same-cycle write bypass.
// A clear sweep zeroes one entry per cycle (DEPTH cycles); o_ready low and reads forced to 0 while sweeping.
module regfile_clr_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_raddr1,
  input  logic [ADDR_W-1:0] i_raddr2,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2,
  output logic              o_ready,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_ready = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        o_ready = 1'b1;
        if (i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign o_busy = ~o_ready;
  assign wr_en  = o_ready && i_we && !((ZERO_REG != 0) && (i_waddr == '0));

  // Array is deliberately unreset; the sweep provides the known-zero state.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= '0;
    end else if (wr_en) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = '0;
    if (o_ready) begin
      if ((ZERO_REG != 0) && (i_raddr1 == '0)) begin
        o_rdata1 = '0;
      end else if ((BYPASS != 0) && i_we && (i_raddr1 == i_waddr)) begin
        o_rdata1 = i_wdata;
      end else begin
        o_rdata1 = mem_q[i_raddr1];
      end
    end
  end

  always_comb begin
    o_rdata2 = '0;
    if (o_ready) begin
      if ((ZERO_REG != 0) && (i_raddr2 == '0)) begin
        o_rdata2 = '0;
      end else if ((BYPASS != 0) && i_we && (i_raddr2 == i_waddr)) begin
        o_rdata2 = i_wdata;
      end else begin
        o_rdata2 = mem_q[i_raddr2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_clr_bypass.sv
// Directed bench: one bypassing and one non-bypassing instance share the same stimulus.
module tb_regfile_clr_bypass;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [4:0]  raddr1, raddr2, waddr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
  logic        ready, busy, nb_ready, nb_busy;

  int total = 0;
  int bad   = 0;
  int cycles;

  regfile_clr_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_raddr1(raddr1), .i_raddr2(raddr2), .i_waddr(waddr),
    .i_wdata(wdata), .i_we(we),
    .o_rdata1(rd1), .o_rdata2(rd2), .o_ready(ready), .o_busy(busy)
  );

  regfile_clr_bypass #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_raddr1(raddr1), .i_raddr2(raddr2), .i_waddr(waddr),
    .i_wdata(wdata), .i_we(we),
    .o_rdata1(nb_rd1), .o_rdata2(nb_rd2), .o_ready(nb_ready), .o_busy(nb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps clocks until o_ready rises; returns cycle count or -1 if it never does.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; we = 1'b0;
    raddr1 = 5'd4; raddr2 = 5'd9; waddr = 5'd0; wdata = '0;

    // Reset state
    tick(); tick();
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy",  {31'd0, busy},  32'd1);
    check("rst_rd1",   rd1, 32'd0);
    check("rst_rd2",   rd2, 32'd0);

    // Power-up sweep of exactly 32 cycles, writes ignored meanwhile
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_F00D;
    for (int i = 1; i <= 31; i++) tick();
    check("sweep_31_ready", {31'd0, ready}, 32'd0);
    check("sweep_31_rd1",   rd1, 32'd0);
    we = 1'b0;
    tick();
    check("sweep_32_ready", {31'd0, ready}, 32'd1);
    check("sweep_32_busy",  {31'd0, busy},  32'd0);
    check("nb_sweep_ready", {31'd0, nb_ready}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      check($sformatf("init_rd1[%0d]", i), rd1, 32'd0);
      check($sformatf("init_rd2[%0d]", 31 - i), rd2, 32'd0);
    end

    // Plain write then read on both ports
    we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd7;
    #1;
    check("wr7_rd1", rd1, 32'hDEAD_BEEF);
    check("wr7_rd2", rd2, 32'hDEAD_BEEF);
    check("wr7_nb_rd1", nb_rd1, 32'hDEAD_BEEF);
    raddr1 = 5'd6;
    #1;
    check("e6_zero", rd1, 32'd0);

    // Entry 0 is hardwired to zero, even with write bypass in flight
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234_5678; raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    check("r0_bypass_rd1", rd1, 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("r0_rd1", rd1, 32'd0);
    check("r0_rd2", rd2, 32'd0);
    tick();
    check("r0_later_rd2", rd2, 32'd0);

    // Same-cycle bypass vs. no bypass
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; raddr1 = 5'd3; raddr2 = 5'd7;
    #1;
    check("byp_same_rd1", rd1, 32'hA5A5_A5A5);
    check("byp_same_rd2", rd2, 32'hDEAD_BEEF);
    check("nobyp_same_rd1", nb_rd1, 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("byp_next_rd1", rd1, 32'hA5A5_A5A5);
    check("nobyp_next_rd1", nb_rd1, 32'hA5A5_A5A5);

    // Fill 1..31, then clear together with a write to entry 5
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'h1000_0000 + 32'(i);
      tick();
    end
    we = 1'b0; raddr1 = 5'd31; raddr2 = 5'd5;
    #1;
    check("fill_rd1_31", rd1, 32'h1000_001F);
    check("fill_rd2_5",  rd2, 32'h1000_0005);
    clear = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'h1;
    tick();
    clear = 1'b0; waddr = 5'd9; wdata = 32'hFFFF_FFFF;
    #1;
    check("clr_ready", {31'd0, ready}, 32'd0);
    check("clr_busy",  {31'd0, busy},  32'd1);
    check("clr_rd1",   rd1, 32'd0);
    wait_ready(cycles);
    we = 1'b0;
    check("clr_cycles", 32'(cycles), 32'd32);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      check($sformatf("post_clr_rd1[%0d]", i), rd1, 32'd0);
      check($sformatf("post_clr_nb_rd2[%0d]", i), nb_rd2, 32'd0);
    end

    // Reset at sweep count 10 restarts a full sweep
    we = 1'b1; waddr = 5'd20; wdata = 32'h5555_AAAA;
    tick();
    we = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_busy",  {31'd0, busy},  32'd1);
    tick();
    rst_n = 1'b1;
    wait_ready(cycles);
    check("midrst_cycles", 32'(cycles), 32'd32);
    check("midrst_busy_after", {31'd0, busy}, 32'd0);
    raddr1 = 5'd20;
    #1;
    check("midrst_e20", rd1, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_clr_bypass.md
Name: regfile_clr_bypass

Overview:
- Next-generation register file for the MIPS datapath core.
- Width and depth are set by parameters. It has two combinational read ports and one synchronous write port.
- A write-to-read bypass lets the decode stage see the value being written back in the same cycle.
- A hardware clear sequencer zeroes every entry after reset or on request, so the array itself needs no reset.

Parameters:
- DATA_W, 32, data width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, when 1: entry 0 always reads 0 and writes to it are dropped.
- BYPASS, 1, when 1: a read of the address being written returns i_wdata combinationally.

Ports:
- i_clk, input, 1, clock; all state updates on the rising edge.
- i_rst_n, input, 1, reset; asynchronous, active-low.
- i_clear, input, 1, single-cycle pulse that starts a clear sweep.
- i_raddr1, input, ADDR_W, read port 1 address.
- i_raddr2, input, ADDR_W, read port 2 address.
- i_waddr, input, ADDR_W, write address.
- i_wdata, input, DATA_W, write data.
- i_we, input, 1, write enable.
- o_rdata1, output, DATA_W, read port 1 data (combinational).
- o_rdata2, output, DATA_W, read port 2 data (combinational).
- o_ready, output, 1, high when in RUN; normal reads and writes are valid.
- o_busy, output, 1, high while in CLEAR.

Behaviour:
- Storage: DEPTH x DATA_W array with no reset. Only the control logic is reset: the state register and the sweep counter.
- Reset (i_rst_n low, asynchronous):
  - state = CLEAR, sweep counter = 0.
  - o_ready = 0, o_busy = 1.
  - o_rdata1 and o_rdata2 read 0 throughout.
- FSM, two states:
  - CLEAR:
    - Each cycle writes 0 to mem[cnt], then cnt increments.
    - When cnt == DEPTH-1 and that entry is written, the next state is RUN.
    - A full sweep takes exactly DEPTH cycles after reset deasserts.
    - o_ready rises on the first edge after entry DEPTH-1 is written.
  - RUN:
    - i_clear = 1 moves the FSM to CLEAR on the next edge with cnt = 0.
    - Otherwise it stays in RUN.
- During CLEAR:
  - i_we is ignored.
  - Both read ports return 0, whatever the array currently holds.
  - i_clear is ignored.
- Write (RUN only):
  - On the rising edge with i_we = 1, mem[i_waddr] <= i_wdata.
  - With ZERO_REG = 1 and i_waddr == 0, the write is dropped.
- Write and i_clear in the same RUN cycle: the write is performed on that edge and CLEAR starts on the next edge. The sweep then zeroes that entry as well.
- Read, RUN, for each port independently:
  1. If ZERO_REG = 1 and raddr == 0, the port reads 0.
  2. Otherwise, if BYPASS = 1, i_we = 1 and raddr == waddr, the port reads i_wdata.
  3. Otherwise the port reads mem[raddr].
- With BYPASS = 0, a same-cycle read returns the old value; the new value is visible from the next cycle.
- Both ports may address the same entry; they return identical data.
- Reset mid-sweep restarts the sweep from cnt = 0. There is no partial-completion state.
- Sweep counter width: ADDR_W+1 bits, so that DEPTH = 2**ADDR_W terminates without wrap ambiguity.
- o_busy = ~o_ready at all times.

Test Plan:
1. Release i_rst_n with DATA_W = 32, ADDR_W = 5 -> o_ready stays low for exactly 32 cycles, then goes high. Reading all 32 entries returns 0x00000000.
2. RUN: write 0xDEADBEEF to entry 7, then read ports 1 and 2 at entry 7 on the next cycle -> both read 0xDEADBEEF. Entry 6 still reads 0.
3. Write 0x12345678 to entry 0 with ZERO_REG = 1 -> entry 0 reads 0 on both ports on every later cycle.
4. BYPASS = 1: in one cycle, i_we = 1, waddr = 3, wdata = 0xA5A5A5A5, raddr1 = 3 -> o_rdata1 = 0xA5A5A5A5 in that same cycle. The same stimulus with BYPASS = 0 -> old value in that cycle, new value in the next cycle.
5. Fill entries 1..31 with nonzero data, pulse i_clear together with a write of 0x1 to entry 5 -> o_ready is low for 32 cycles; writes issued during CLEAR are ignored; afterwards every entry, including 5, reads 0.
6. Assert i_rst_n low at sweep count 10, then release -> a full 32-cycle sweep reruns before o_ready goes high.
